// File: rtl/sprite_list_buffer_if.sv
// Record bus between the sprite list buffer and its neighbours: the processor
// write strobe on one side and the renderer valid/ready channel on the other.
interface sprite_list_buffer_if #(
  parameter int X_W = 9,
  parameter int Y_W = 10,
  parameter int F_W = 3
) ();

  logic           in_valid;
  logic [X_W-1:0] in_x;
  logic [Y_W-1:0] in_y;
  logic [F_W-1:0] in_frame;

  logic           out_valid;
  logic           out_ready;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic [F_W-1:0] out_frame;
  logic           out_last;

  // Processor and renderer side, as driven by whoever feeds and drains the buffer.
  modport master (
    output in_valid, in_x, in_y, in_frame, out_ready,
    input  out_valid, out_x, out_y, out_frame, out_last
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_x, in_y, in_frame, out_ready,
    output out_valid, out_x, out_y, out_frame, out_last
  );

endinterface

// File: rtl/sprite_list_buffer.sv
// Double-buffered sprite command list: records written during one video frame
// are frozen at new_frame and replayed to the renderer during the next frame.
module sprite_list_buffer #(
  parameter int CANVAS_WIDTH  = 360,
  parameter int CANVAS_HEIGHT = 720,
  parameter int NUM_FRAMES    = 5,
  parameter int MAX_SPRITES   = 64
) (
  input  logic                               clk_pixel_in,
  input  logic                               rst_n_in,
  input  logic                               new_frame_in,
  sprite_list_buffer_if.slave                bus,
  output logic [$clog2(MAX_SPRITES+1)-1:0]   count_out,
  output logic                               overflow_out,
  output logic                               late_out,
  output logic [1:0]                         dbg_state_out
);

  localparam int X_W       = $clog2(CANVAS_WIDTH);
  localparam int Y_W       = $clog2(CANVAS_HEIGHT);
  localparam int F_W       = $clog2(NUM_FRAMES);
  localparam int C_W       = $clog2(MAX_SPRITES + 1);
  localparam int A_W       = $clog2(MAX_SPRITES);
  localparam int D_W       = F_W + Y_W + X_W;
  localparam int RAM_DEPTH = 2 * (2 ** A_W);

  localparam logic [C_W-1:0] MAX_CNT = C_W'(MAX_SPRITES);
  localparam logic [C_W-1:0] ONE     = C_W'(1);

  // dbg_state_out reports this encoding directly: 0 idle, 1 fetch, 2 present.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            wr_bank_q, wr_bank_d;
  logic [C_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [C_W-1:0]  rd_len_q, rd_len_d;
  logic [C_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            ovf_clr_q, ovf_clr_d;
  logic            late_q, late_d;

  logic [D_W-1:0]  mem [RAM_DEPTH];
  logic [D_W-1:0]  rd_data_q;

  logic            wr_accept;
  logic            wr_drop;
  logic            wr_en;
  logic            rd_en;
  logic            in_present;
  logic            is_last;
  logic            hs;
  logic [C_W-1:0]  wr_cnt_next;
  logic [A_W:0]    wr_addr;
  logic [A_W:0]    rd_addr;
  logic [D_W-1:0]  wr_data;

  // Renderer channel: a record transfers on any clock edge where out_valid and
  // out_ready are both high. While out_valid is high the record and out_last
  // stay stable until that transfer; the only exception is a bank swap, which
  // withdraws out_valid on the following cycle without a transfer.

  assign wr_accept  = bus.in_valid && (wr_cnt_q < MAX_CNT);
  assign wr_drop    = bus.in_valid && (wr_cnt_q == MAX_CNT);
  assign wr_en      = wr_accept && rst_n_in;
  assign wr_addr    = {wr_bank_q, wr_cnt_q[A_W-1:0]};
  assign wr_data    = {bus.in_frame, bus.in_y, bus.in_x};

  // The read bank is always the one the processor is not writing.
  assign rd_addr    = {~wr_bank_q, rd_ptr_q[A_W-1:0]};
  assign rd_en      = (state_q == S_FETCH);

  assign in_present = (state_q == S_PRESENT);
  assign is_last    = in_present && (rd_ptr_q == rd_len_q - ONE);
  assign hs         = in_present && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_next = wr_accept ? wr_cnt_q + ONE : wr_cnt_q;
    wr_cnt_d    = wr_cnt_next;
    rd_len_d    = rd_len_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = (ovf_clr_q ? 1'b0 : overflow_q) | wr_drop;
    ovf_clr_d   = 1'b0;
    late_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_FETCH: begin
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (hs) begin
          rd_ptr_d = rd_ptr_q + ONE;
          state_d  = is_last ? S_IDLE : S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A swap overrides any readout step; a write in the same cycle still
    // lands in the old bank and is counted into the frozen list.
    if (new_frame_in) begin
      wr_bank_d  = ~wr_bank_q;
      rd_len_d   = wr_cnt_next;
      wr_cnt_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = wr_drop;
      ovf_clr_d  = 1'b1;
      late_d     = (state_q != S_IDLE) && (rd_ptr_q < rd_len_q);
      state_d    = (wr_cnt_next != '0) ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_len_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      ovf_clr_q  <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_len_q   <= rd_len_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      ovf_clr_q  <= ovf_clr_d;
      late_q     <= late_d;
    end
  end

  // Both banks share one synchronous-read array addressed by {bank, index}.
  always_ff @(posedge clk_pixel_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // Data outputs are forced to zero outside PRESENT so reset needs no RAM clear.
  assign bus.out_valid = in_present;
  assign bus.out_last  = is_last;
  assign bus.out_x     = in_present ? rd_data_q[X_W-1:0]             : '0;
  assign bus.out_y     = in_present ? rd_data_q[X_W+Y_W-1:X_W]       : '0;
  assign bus.out_frame = in_present ? rd_data_q[D_W-1:X_W+Y_W]       : '0;

  assign count_out     = rd_len_q;
  assign overflow_out  = overflow_q;
  assign late_out      = late_q;
  assign dbg_state_out = state_q;

endmodule

// File: tb/tb_sprite_list_buffer.sv
// Bench for sprite_list_buffer: directed scenarios plus random frames, checked
// against a queue model of the write list and the frozen read list.
module tb_sprite_list_buffer;

  localparam int MAXS = 64;
  localparam int CW   = 360;
  localparam int CH   = 720;
  localparam int NF   = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_frame;
  logic [6:0] count_out;
  logic       overflow_out;
  logic       late_out;
  logic [1:0] dbg_state;

  sprite_list_buffer_if bus ();

  sprite_list_buffer dut (
    .clk_pixel_in  (clk),
    .rst_n_in      (rst_n),
    .new_frame_in  (new_frame),
    .bus           (bus),
    .count_out     (count_out),
    .overflow_out  (overflow_out),
    .late_out      (late_out),
    .dbg_state_out (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: records of the frame being written, and records still owed to the renderer.
  logic [21:0] wr_q[$];
  logic [21:0] exp_q[$];
  bit          model_ovf;

  function automatic logic [21:0] pack(input logic [8:0] x, input logic [9:0] y,
                                       input logic [2:0] f);
    return {f, y, x};
  endfunction

  function automatic logic [21:0] rand_rec();
    logic [8:0] x;
    logic [9:0] y;
    logic [2:0] f;
    x = 9'($urandom_range(CW - 1));
    y = 10'($urandom_range(CH - 1));
    f = 3'($urandom_range(NF - 1));
    return pack(x, y, f);
  endfunction

  function automatic logic [21:0] cur_rec();
    return {bus.out_frame, bus.out_y, bus.out_x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic [21:0] r);
    {bus.in_frame, bus.in_y, bus.in_x} = r;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_data"}, cur_rec(), 0);
    chk({tag, "_count"}, count_out, 0);
    chk({tag, "_ovf"}, overflow_out, 0);
    chk({tag, "_late"}, late_out, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      bus.in_valid  = 1'b1;
      drive_in(rand_rec());
      new_frame     = 1'($urandom_range(1));
      bus.out_ready = 1'($urandom_range(1));
      tick();
      chk_zero("reset");
    end
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    new_frame     = 1'b0;
    bus.out_ready = 1'b0;
    wr_q.delete();
    exp_q.delete();
    model_ovf = 0;
  endtask

  task automatic write_rec(input logic [21:0] r);
    bus.out_ready = 1'b0;
    drive_in(r);
    bus.in_valid = 1'b1;
    if (wr_q.size() < MAXS) wr_q.push_back(r);
    else model_ovf = 1;
    tick();
    bus.in_valid = 1'b0;
    chk("ovf_sticky", overflow_out, model_ovf);
  endtask

  task automatic do_swap(input bit with_rec, input logic [21:0] r);
    bit exp_late;
    bit exp_drop;
    exp_late = (exp_q.size() != 0);
    exp_drop = 0;
    bus.out_ready = 1'b0;
    new_frame     = 1'b1;
    if (with_rec) begin
      drive_in(r);
      bus.in_valid = 1'b1;
      if (wr_q.size() < MAXS) wr_q.push_back(r);
      else exp_drop = 1;
    end
    tick();
    new_frame    = 1'b0;
    bus.in_valid = 1'b0;
    exp_q = wr_q;
    wr_q.delete();
    model_ovf = 0;
    chk("swap_count", count_out, exp_q.size());
    chk("swap_late", late_out, exp_late);
    chk("swap_ovf", overflow_out, exp_drop);
    chk("swap_valid", bus.out_valid, 0);
    tick();
    chk("late_end", late_out, 0);
    chk("ovf_clear", overflow_out, 0);
    chk("first_valid", bus.out_valid, exp_q.size() != 0);
  endtask

  // Consume owed records with a random ready pattern; max_hs=0 means drain all.
  task automatic drain(input int pct, input int max_hs, input int stall, input int budget);
    int cyc;
    int hs;
    bit prev_stall;
    bit prev_hs;
    cyc = 0;
    hs = 0;
    prev_stall = 0;
    prev_hs = 0;
    while (exp_q.size() != 0 && (max_hs == 0 || hs < max_hs) && cyc < budget) begin
      if (prev_stall) chk("valid_hold", bus.out_valid, 1);
      if (prev_hs) chk("valid_gap", bus.out_valid, 0);
      bus.out_ready = (cyc >= stall) && ($urandom_range(99) < pct);
      prev_stall = 0;
      prev_hs = 0;
      if (bus.out_valid) begin
        chk("rec", cur_rec(), exp_q[0]);
        chk("last", bus.out_last, exp_q.size() == 1);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          hs++;
          prev_hs = 1;
        end else begin
          prev_stall = 1;
        end
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (cyc >= budget) chk("drain_timeout", exp_q.size(), 0);
    if (exp_q.size() == 0) begin
      chk("done_idle", bus.out_valid, 0);
      repeat (2) begin
        tick();
        chk("stay_idle", bus.out_valid, 0);
      end
    end
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    new_frame     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_frame  = '0;
    bus.out_ready = 1'b0;
    model_ovf     = 0;

    // Reset with in_valid held high, then an empty swap.
    do_reset(3);
    do_swap(0, '0);
    repeat (3) begin
      tick();
      chk("empty_no_valid", bus.out_valid, 0);
    end

    // Three fixed records, renderer always ready.
    write_rec(pack(10, 20, 1));
    write_rec(pack(30, 40, 2));
    write_rec(pack(359, 719, 4));
    do_swap(0, '0);
    drain(100, 0, 0, 200);

    // Same records, renderer stalls for 10 cycles first.
    write_rec(pack(10, 20, 1));
    write_rec(pack(30, 40, 2));
    write_rec(pack(359, 719, 4));
    do_swap(0, '0);
    drain(100, 0, 10, 200);

    // 65 writes: the last one is dropped and flags overflow.
    for (int i = 0; i < 65; i++) write_rec(rand_rec());
    do_swap(0, '0);
    drain(60, 0, 0, 1000);

    // Full bank plus a coincident write in the swap cycle: drop seen for one cycle.
    for (int i = 0; i < 64; i++) write_rec(rand_rec());
    do_swap(1, rand_rec());
    drain(100, 0, 0, 400);

    // Readout of 5 aborted after 2 transfers by a swap carrying 4 new records.
    for (int i = 0; i < 5; i++) write_rec(rand_rec());
    do_swap(0, '0);
    drain(100, 2, 0, 100);
    for (int i = 0; i < 4; i++) write_rec(rand_rec());
    do_swap(0, '0);
    drain(70, 0, 0, 200);

    // Write coincident with the swap becomes the final record.
    write_rec(rand_rec());
    write_rec(rand_rec());
    do_swap(1, rand_rec());
    drain(50, 0, 0, 200);

    // Reset in the middle of a readout discards it without a late pulse.
    for (int i = 0; i < 3; i++) write_rec(rand_rec());
    do_swap(0, '0);
    drain(100, 1, 0, 50);
    do_reset(1);
    do_swap(0, '0);

    // Random frames.
    repeat (20) begin
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) write_rec(rand_rec());
      do_swap(1'($urandom_range(1)), rand_rec());
      drain($urandom_range(20, 100), 0, 0, 600);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
